// File: rtl/incr_decr_scan_if.sv
// Request handshake between a requester and the incr_decr_scan unit.
// The requester holds data_in/a_s/val_op until op_ack, then waits for op_commit.
interface incr_decr_scan_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             a_s;
    logic             val_op;
    logic             op_ack;
    logic             op_commit;
    logic [WIDTH-1:0] data_out;

    modport master (
        output data_in, a_s, val_op,
        input  op_ack, op_commit, data_out
    );

    modport slave (
        input  data_in, a_s, val_op,
        output op_ack, op_commit, data_out
    );
endinterface

// File: rtl/incr_decr_scan.sv
// Increment/decrement leaf unit with a four-state request FSM.
// Every flop is on one scan chain: {op_commit, op_ack, state, op_reg, operand, data_out}.
module incr_decr_scan #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    incr_decr_scan_if.slave    bus,
    input  logic               sen,
    input  logic               scan_ce,
    input  logic               sin,
    output logic               sout
);
    localparam int CHAIN = 2 * WIDTH + 5;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACK    = 2'b01;
    localparam logic [1:0] CALC   = 2'b10;
    localparam logic [1:0] COMMIT = 2'b11;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] operand, operand_nxt;
    logic [WIDTH-1:0] result, result_nxt;
    logic             op_reg, op_reg_nxt;
    logic             ack, ack_nxt;
    logic             commit, commit_nxt;
    logic [CHAIN-1:0] chain;

    // Modulo-2^WIDTH step; wrap-around is intentional, no carry/borrow is kept.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic up);
        return up ? v + WIDTH'(1) : v - WIDTH'(1);
    endfunction

    assign chain = {commit, ack, state, op_reg, operand, result};
    assign sout  = chain[0];

    assign bus.op_ack    = ack;
    assign bus.op_commit = commit;
    assign bus.data_out  = result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            operand <= '0;
            op_reg  <= 1'b0;
            result  <= '0;
            ack     <= 1'b0;
            commit  <= 1'b0;
        end else if (scan_ce) begin
            // scan_ce freezes the function; sen chooses shift over hold.
            if (sen) begin
                {commit, ack, state, op_reg, operand, result} <= {sin, chain[CHAIN-1:1]};
            end
        end else begin
            state   <= state_nxt;
            operand <= operand_nxt;
            op_reg  <= op_reg_nxt;
            result  <= result_nxt;
            ack     <= ack_nxt;
            commit  <= commit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.val_op) state_nxt = ACK;
            ACK:     state_nxt = CALC;
            CALC:    state_nxt = COMMIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        operand_nxt = operand;
        op_reg_nxt  = op_reg;
        result_nxt  = result;
        ack_nxt     = 1'b0;
        commit_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.val_op) begin
                    operand_nxt = bus.data_in;
                    op_reg_nxt  = bus.a_s;
                    ack_nxt     = 1'b1;
                end
            end
            CALC: begin
                result_nxt = step(operand, op_reg);
                commit_nxt = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_incr_decr_scan.sv
// Directed bench for incr_decr_scan: handshake timing, wrap-around, freeze, scan unload/load, reset abort.
module tb_incr_decr_scan;
    logic clk = 1'b0;
    logic reset, sen, scan_ce, sin, sout;
    int   n_checks = 0;
    int   n_fail   = 0;

    incr_decr_scan_if #(.WIDTH(8)) bus ();

    incr_decr_scan #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sen     (sen),
        .scan_ce (scan_ce),
        .sin     (sin),
        .sout    (sout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one request, holding val_op until op_ack (bounded), then waits for op_commit (bounded).
    task automatic run_txn(input logic [7:0] din, input logic up,
                           output logic [7:0] res, output int ack_wait, output int commit_wait);
        bus.data_in = din;
        bus.a_s     = up;
        bus.val_op  = 1'b1;
        ack_wait    = 0;
        do begin
            tick();
            ack_wait++;
        end while (!bus.op_ack && ack_wait < 6);
        bus.val_op  = 1'b0;
        bus.data_in = ~din;
        bus.a_s     = ~up;
        commit_wait = 0;
        do begin
            tick();
            commit_wait++;
        end while (!bus.op_commit && commit_wait < 6);
        res = bus.data_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (6) tick();
        if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h required 00", bus.data_out); end
        n_checks++;
        if (bus.op_ack !== 1'b0) begin n_fail++; $display("FAIL reset_op_ack: got %b required 0", bus.op_ack); end
        n_checks++;
        if (bus.op_commit !== 1'b0) begin n_fail++; $display("FAIL reset_op_commit: got %b required 0", bus.op_commit); end
        n_checks++;
        if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b required 0", sout); end
        n_checks++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        bus.data_in = 8'h24;
        bus.a_s     = 1'b1;
        bus.val_op  = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.op_ack && n < 6);
        if (n !== 1) begin n_fail++; $display("FAIL basic_ack_latency: got %0d required 1", n); end
        n_checks++;
        bus.val_op = 1'b0;
        if (bus.op_commit !== 1'b0) begin n_fail++; $display("FAIL basic_commit_early: got %b required 0", bus.op_commit); end
        n_checks++;
        tick();
        if (bus.op_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_width: got %b required 0", bus.op_ack); end
        n_checks++;
        if (bus.op_commit !== 1'b0) begin n_fail++; $display("FAIL basic_commit_k1: got %b required 0", bus.op_commit); end
        n_checks++;
        tick();
        if (bus.op_commit !== 1'b1) begin n_fail++; $display("FAIL basic_commit: got %b required 1", bus.op_commit); end
        n_checks++;
        if (bus.data_out !== 8'h25) begin n_fail++; $display("FAIL basic_data_out: got %h required 25", bus.data_out); end
        n_checks++;
        tick();
        if (bus.op_commit !== 1'b0) begin n_fail++; $display("FAIL basic_commit_width: got %b required 0", bus.op_commit); end
        n_checks++;
        repeat (2) tick();
        if (bus.data_out !== 8'h25) begin n_fail++; $display("FAIL basic_hold: got %h required 25", bus.data_out); end
        n_checks++;
    endtask

    task automatic test_boundaries();
        logic [7:0] din [3]  = '{8'hFF, 8'h00, 8'h81};
        logic       up  [3]  = '{1'b1, 1'b0, 1'b0};
        logic [7:0] expv [3] = '{8'h00, 8'hFF, 8'h80};
        logic [7:0] res;
        int aw, cw;
        for (int i = 0; i < 3; i++) begin
            run_txn(din[i], up[i], res, aw, cw);
            if (res !== expv[i]) begin n_fail++; $display("FAIL boundary_%0d: got %h required %h", i, res, expv[i]); end
            n_checks++;
            if (cw !== 2) begin n_fail++; $display("FAIL boundary_latency_%0d: got %0d required 2", i, cw); end
            n_checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] din, res, expv;
        logic       up;
        int aw, cw;
        for (int i = 0; i < 10; i++) begin
            din  = 8'($urandom_range(0, 255));
            up   = 1'($urandom_range(0, 1));
            expv = up ? din + 8'd1 : din - 8'd1;
            run_txn(din, up, res, aw, cw);
            if (res !== expv) begin n_fail++; $display("FAIL b2b_result_%0d: got %h required %h", i, res, expv); end
            n_checks++;
            if (aw > 2 || cw !== 2) begin n_fail++; $display("FAIL b2b_latency_%0d: got ack %0d commit %0d required ack<=2 commit 2", i, aw, cw); end
            n_checks++;
        end
        tick();
    endtask

    task automatic test_freeze();
        bus.data_in = 8'h5A;
        bus.a_s     = 1'b0;
        bus.val_op  = 1'b1;
        tick();
        bus.val_op  = 1'b0;
        if (bus.op_ack !== 1'b1) begin n_fail++; $display("FAIL freeze_ack: got %b required 1", bus.op_ack); end
        n_checks++;
        scan_ce = 1'b1;
        sen     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.op_ack !== 1'b1 || bus.op_commit !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_hold_%0d: got ack %b commit %b required ack 1 commit 0", i, bus.op_ack, bus.op_commit);
            end
            n_checks++;
        end
        scan_ce = 1'b0;
        tick();
        if (bus.op_ack !== 1'b0) begin n_fail++; $display("FAIL freeze_release_ack: got %b required 0", bus.op_ack); end
        n_checks++;
        tick();
        if (bus.op_commit !== 1'b1 || bus.data_out !== 8'h59) begin
            n_fail++;
            $display("FAIL freeze_result: got commit %b data %h required commit 1 data 59", bus.op_commit, bus.data_out);
        end
        n_checks++;
        tick();
    endtask

    task automatic test_scan();
        logic [20:0] unload_exp = {1'b0, 1'b0, 2'b00, 1'b1, 8'h24, 8'h25};
        logic [20:0] load_pat   = {1'b0, 1'b0, 2'b10, 1'b1, 8'h7F, 8'h3D};
        logic [7:0]  res;
        int aw, cw;
        run_txn(8'h24, 1'b1, res, aw, cw);
        if (res !== 8'h25) begin n_fail++; $display("FAIL scan_setup: got %h required 25", res); end
        n_checks++;
        tick();
        scan_ce = 1'b1;
        sen     = 1'b1;
        for (int i = 0; i < 21; i++) begin
            sin = load_pat[i];
            if (sout !== unload_exp[i]) begin n_fail++; $display("FAIL scan_unload_bit_%0d: got %b required %b", i, sout, unload_exp[i]); end
            n_checks++;
            tick();
        end
        sen = 1'b0;
        sin = 1'b0;
        tick();
        if (bus.data_out !== 8'h3D || bus.op_ack !== 1'b0 || bus.op_commit !== 1'b0 || sout !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_loaded: got data %h ack %b commit %b sout %b required 3d 0 0 1",
                     bus.data_out, bus.op_ack, bus.op_commit, sout);
        end
        n_checks++;
        scan_ce = 1'b0;
        tick();
        if (bus.op_commit !== 1'b1 || bus.data_out !== 8'h80) begin
            n_fail++;
            $display("FAIL scan_resume: got commit %b data %h required commit 1 data 80", bus.op_commit, bus.data_out);
        end
        n_checks++;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] res;
        int aw, cw;
        bus.data_in = 8'h10;
        bus.a_s     = 1'b1;
        bus.val_op  = 1'b1;
        tick();
        bus.val_op  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (bus.data_out !== 8'h00 || bus.op_ack !== 1'b0 || bus.op_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got data %h ack %b commit %b required 00 0 0", bus.data_out, bus.op_ack, bus.op_commit);
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.op_commit !== 1'b0 || bus.data_out !== 8'h00) begin
                n_fail++;
                $display("FAIL midreset_no_commit_%0d: got commit %b data %h required 0 00", i, bus.op_commit, bus.data_out);
            end
            n_checks++;
        end
        run_txn(8'h30, 1'b0, res, aw, cw);
        if (aw !== 1 || res !== 8'h2F) begin
            n_fail++;
            $display("FAIL midreset_idle: got ack_wait %0d data %h required 1 2f", aw, res);
        end
        n_checks++;
    endtask

    initial begin
        reset       = 1'b1;
        sen         = 1'b0;
        scan_ce     = 1'b0;
        sin         = 1'b0;
        bus.data_in = 8'h00;
        bus.a_s     = 1'b0;
        bus.val_op  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_freeze();
        test_scan();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
